// File: rtl/ide_pio_sequencer.sv
// IDE PIO sequencer: turns a decoded 68030 IDE access (AS20/RW20/IDESEL)
// into IDE chip-select and read/write strobes. Setup, strobe, hold and
// recovery lengths are programmable. IORDY (IDEWAIT) can stretch the strobe.
// The CPU cycle is terminated with DSACK1 for a 16-bit port.
//
// Handshake: a cycle is requested while AS20 is low with IDESEL high and the
// sequencer is IDLE. DSACK1 acknowledges the request and stays low until the
// CPU negates AS20. Requests seen while BUSY are ignored until IDLE, because
// nothing is queued. An AS20 negation before ACK aborts the cycle without
// asserting DSACK1.
module ide_pio_sequencer #(
  parameter int T_SETUP   = 2,
  parameter int T_STROBE  = 6,
  parameter int T_HOLD    = 2,
  parameter int T_RECOVER = 3,
  parameter int T_TIMEOUT = 255
) (
  input  logic       CLKCPU,
  input  logic       RESET,
  input  logic       AS20,
  input  logic       RW20,
  input  logic       IDESEL,
  input  logic       CSSEL,
  input  logic       IDEWAIT,
  output logic [1:0] IDECS,
  output logic       IOR,
  output logic       IOW,
  output logic       DSACK1,
  output logic       TIMEOUT,
  output logic       BUSY,
  output logic [2:0] DBG_STATE
);

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_SETUP   = 3'd1;
  localparam logic [2:0] S_STROBE  = 3'd2;
  localparam logic [2:0] S_WAITRDY = 3'd3;
  localparam logic [2:0] S_ACK     = 3'd4;
  localparam logic [2:0] S_HOLD    = 3'd5;
  localparam logic [2:0] S_RECOVER = 3'd6;

  // Phase reload values. SETUP, HOLD and RECOVER count down to zero and leave
  // on the edge that sees zero, so they last exactly T_x cycles. STROBE is
  // loaded with the full T_STROBE so that, after T_STROBE strobe-low cycles,
  // one further cycle is spent sampling IORDY before choosing ACK or WAITRDY.
  localparam logic [3:0] SETUP_LD   = 4'(T_SETUP - 1);
  localparam logic [3:0] STROBE_LD  = 4'(T_STROBE);
  localparam logic [3:0] HOLD_LD    = 4'(T_HOLD - 1);
  localparam logic [3:0] RECOVER_LD = (T_RECOVER == 0) ? 4'd0 : 4'(T_RECOVER - 1);
  localparam logic [7:0] WAIT_LAST  = 8'(T_TIMEOUT - 1);

  logic [2:0] state_q, state_d;
  logic [3:0] phase_q, phase_d;
  logic [7:0] wait_q, wait_d;
  logic       rw_q, rw_d;
  logic       sel_q, sel_d;
  logic       timeout_d;

  logic [1:0] idecs_d;
  logic       ior_d, iow_d, dsack_d, busy_d;
  logic       cs_act, strobe_act;

  // Next-state, phase counter and wait counter.
  always_comb begin
    state_d   = state_q;
    phase_d   = phase_q;
    wait_d    = wait_q;
    rw_d      = rw_q;
    sel_d     = sel_q;
    timeout_d = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (!AS20 && IDESEL) begin
          state_d = S_SETUP;
          phase_d = SETUP_LD;
          rw_d    = RW20;
          sel_d   = CSSEL;
        end
      end
      S_SETUP: begin
        if (AS20) begin
          state_d = S_HOLD;
          phase_d = HOLD_LD;
        end else if (phase_q == 4'd0) begin
          state_d = S_STROBE;
          phase_d = STROBE_LD;
        end else begin
          phase_d = phase_q - 4'd1;
        end
      end
      S_STROBE: begin
        if (AS20) begin
          state_d = S_HOLD;
          phase_d = HOLD_LD;
        end else if (phase_q == 4'd0) begin
          phase_d = 4'd0;
          if (!IDEWAIT) begin
            state_d = S_WAITRDY;
            wait_d  = 8'd0;
          end else begin
            state_d = S_ACK;
          end
        end else begin
          phase_d = phase_q - 4'd1;
        end
      end
      S_WAITRDY: begin
        if (AS20) begin
          state_d = S_HOLD;
          phase_d = HOLD_LD;
        end else if (IDEWAIT) begin
          state_d = S_ACK;
        end else if (wait_q == WAIT_LAST) begin
          state_d   = S_ACK;
          timeout_d = 1'b1;
        end else begin
          wait_d = wait_q + 8'd1;
        end
      end
      S_ACK: begin
        if (AS20) begin
          state_d = S_HOLD;
          phase_d = HOLD_LD;
        end
      end
      S_HOLD: begin
        if (phase_q == 4'd0) begin
          if (T_RECOVER == 0) begin
            state_d = S_IDLE;
            phase_d = 4'd0;
          end else begin
            state_d = S_RECOVER;
            phase_d = RECOVER_LD;
          end
        end else begin
          phase_d = phase_q - 4'd1;
        end
      end
      S_RECOVER: begin
        if (phase_q == 4'd0) begin
          state_d = S_IDLE;
        end else begin
          phase_d = phase_q - 4'd1;
        end
      end
      default: begin
        state_d = S_IDLE;
        phase_d = 4'd0;
      end
    endcase
  end

  // Output decode from the next state so every output is a plain register.
  always_comb begin
    cs_act     = (state_d == S_SETUP) || (state_d == S_STROBE) ||
                 (state_d == S_WAITRDY) || (state_d == S_ACK) ||
                 (state_d == S_HOLD);
    strobe_act = (state_d == S_STROBE) || (state_d == S_WAITRDY) ||
                 (state_d == S_ACK);
    idecs_d    = 2'b11;
    if (cs_act) begin
      idecs_d = sel_d ? 2'b01 : 2'b10;
    end
    ior_d   = !(strobe_act && rw_d);
    iow_d   = !(strobe_act && !rw_d);
    dsack_d = !(state_d == S_ACK);
    busy_d  = (state_d != S_IDLE);
  end

  // State and output registers, cleared asynchronously.
  always_ff @(posedge CLKCPU or posedge RESET) begin
    if (RESET) begin
      state_q <= S_IDLE;
      phase_q <= 4'd0;
      wait_q  <= 8'd0;
      rw_q    <= 1'b1;
      sel_q   <= 1'b0;
      IDECS   <= 2'b11;
      IOR     <= 1'b1;
      IOW     <= 1'b1;
      DSACK1  <= 1'b1;
      TIMEOUT <= 1'b0;
      BUSY    <= 1'b0;
    end else begin
      state_q <= state_d;
      phase_q <= phase_d;
      wait_q  <= wait_d;
      rw_q    <= rw_d;
      sel_q   <= sel_d;
      IDECS   <= idecs_d;
      IOR     <= ior_d;
      IOW     <= iow_d;
      DSACK1  <= dsack_d;
      TIMEOUT <= timeout_d;
      BUSY    <= busy_d;
    end
  end

  assign DBG_STATE = state_q;

endmodule
